// File: rtl/psg_pkg.sv
// Shared definitions for the PSG frame player.
//   - Sequencer and bus-writer state enumerations. The sequencer owns IDLE/FETCH/mute
//     ordering; each address/data pair, including the optional gap, runs inside the
//     bus writer.
//   - PSG register indices and the envelope "no retrigger" byte.
package psg_pkg;

    localparam int unsigned PSG_NUM_REGS      = 14;
    localparam logic [3:0]  PSG_REG_ENV_SHAPE = 4'hD;
    localparam logic [7:0]  ENV_SKIP_BYTE     = 8'hFF;
    localparam logic [3:0]  PSG_REG_VOL_A     = 4'd8;
    localparam logic [3:0]  PSG_REG_VOL_B     = 4'd9;
    localparam logic [3:0]  PSG_REG_VOL_C     = 4'd10;

    // Frame sequencer. StWrite covers WR_ADDR/WR_DATA/GAP; StMute covers MUTE_ADDR/MUTE_DATA.
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StMute
    } seq_state_e;

    // Bus writer phases for one address/data pair.
    typedef enum logic [1:0] {
        WrIdle,
        WrAddr,
        WrData,
        WrGap
    } wr_state_e;

endpackage

// File: rtl/psg_bus_writer.sv
// Issues one PSG address/data write pair followed by GAP_CYCLES idle cycles.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start              begin a pair; honoured only while idle
//   reg_idx, data      register index and value, sampled on start
//   idle               no pair in progress
//   done               combinational; high in the final cycle of the pair (incl. gap)
//   psg_a0/psg_wren/psg_wrdata  registered PSG bus outputs
module psg_bus_writer
    import psg_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] reg_idx,
    input  logic [7:0] data,
    output logic       idle,
    output logic       done,
    output logic       psg_a0,
    output logic       psg_wren,
    output logic [7:0] psg_wrdata
);

    localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

    wr_state_e  state_q, state_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] data_q;

    assign idle = (state_q == WrIdle);

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        done      = 1'b0;
        unique case (state_q)
            WrIdle: if (start) state_d = WrAddr;
            WrAddr: state_d = WrData;
            WrData: begin
                if (GAP_CYCLES == 0) begin
                    done    = 1'b1;
                    state_d = WrIdle;
                end else begin
                    state_d   = WrGap;
                    gap_cnt_d = 4'd0;
                end
            end
            WrGap: begin
                if (gap_cnt_q == GapLast) begin
                    done    = 1'b1;
                    state_d = WrIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = WrIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WrIdle;
            gap_cnt_q  <= 4'd0;
            data_q     <= 8'h00;
            psg_a0     <= 1'b0;
            psg_wren   <= 1'b0;
            psg_wrdata <= 8'h00;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            if (start && idle) data_q <= data;
            // Bus outputs are decoded from the next state so they are registered yet on time.
            psg_wren <= (state_d == WrAddr) || (state_d == WrData);
            psg_a0   <= (state_d == WrAddr);
            if (state_d == WrAddr)      psg_wrdata <= {4'h0, reg_idx};
            else if (state_d == WrData) psg_wrdata <= data_q;
            else                        psg_wrdata <= 8'h00;
        end
    end

endmodule

// File: rtl/psg_frame_player.sv
// Replays a byte stream of PSG register frames, one frame per frame_tick.
// Each byte i of a frame becomes an address write (a0=1, data=i) followed by a data write.
// Register 13 carrying 8'hFF is skipped (no envelope retrigger). Dropping enable finishes
// the pair in flight, then writes 0 to volume registers 8, 9, 10 (mute).
// Optional macro PSG_PLAYER_SKIP_UNCHANGED_EN: keep shadows of registers 0..12 and skip
// pairs whose byte matches a valid shadow; aborts and reset invalidate all shadows.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   enable                      playback armed (level)
//   frame_tick                  one-cycle frame strobe
//   in_data/in_valid/in_ready   byte stream input
//   psg_a0/psg_wren/psg_wrdata  PSG bus initiator
//   busy                        frame or mute sequence in progress
//   frame_done                  pulse after the last register of a frame
//   overrun, clr_err            sticky tick-while-busy flag and its clear
module psg_frame_player
    import psg_pkg::*;
#(
    parameter int unsigned NUM_REGS   = PSG_NUM_REGS,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       psg_a0,
    output logic       psg_wren,
    output logic [7:0] psg_wrdata,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    input  logic       clr_err
);

    localparam logic [3:0] LastIdx = 4'(NUM_REGS - 1);

    seq_state_e state_q, state_d;
    logic [3:0] reg_idx_q, reg_idx_d;
    logic [1:0] mute_cnt_q, mute_cnt_d;
    logic       muted_q, muted_d;
    logic       frame_done_d, overrun_d;
    logic       hs, skip, unchanged, advance, abort;
    logic       wr_start, wr_idle, wr_done;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;

    // in_ready is only high in StFetch.
    assign hs      = in_valid & in_ready;
    assign wr_idx  = (state_q == StMute) ? PSG_REG_VOL_A + {2'b00, mute_cnt_q} : reg_idx_q;
    assign wr_data = (state_q == StMute) ? 8'h00 : in_data;

`ifdef PSG_PLAYER_SKIP_UNCHANGED_EN
    logic [7:0]  shadow_q [16];
    logic [15:0] shadow_vld_q;

    assign unchanged = (reg_idx_q < PSG_REG_ENV_SHAPE) && shadow_vld_q[reg_idx_q] &&
                       (shadow_q[reg_idx_q] == in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_vld_q <= '0;
            for (int i = 0; i < 16; i++) shadow_q[i] <= 8'h00;
        end else begin
            if (abort) shadow_vld_q <= '0;
            // Frame writes and mute writes both refresh the shadow at issue time.
            if (wr_start && (wr_idx < PSG_REG_ENV_SHAPE)) begin
                shadow_q[wr_idx]     <= wr_data;
                shadow_vld_q[wr_idx] <= 1'b1;
            end
        end
    end
`else
    assign unchanged = 1'b0;
`endif

    assign skip = ((reg_idx_q == PSG_REG_ENV_SHAPE) && (in_data == ENV_SKIP_BYTE)) || unchanged;

    always_comb begin
        state_d      = state_q;
        reg_idx_d    = reg_idx_q;
        mute_cnt_d   = mute_cnt_q;
        muted_d      = muted_q;
        frame_done_d = 1'b0;
        wr_start     = 1'b0;
        advance      = 1'b0;
        abort        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_tick && enable) begin
                    state_d   = StFetch;
                    reg_idx_d = 4'd0;
                end else if (!enable && !muted_q) begin
                    state_d    = StMute;
                    mute_cnt_d = 2'd0;
                end
            end
            StFetch: begin
                if (hs && !skip) begin
                    wr_start = 1'b1;
                    state_d  = StWrite;
                end else if (!enable) begin
                    abort = 1'b1;
                end else if (hs) begin
                    advance = 1'b1;
                end
            end
            StWrite: begin
                // Abort only once the pair is complete so no address write is orphaned.
                if (wr_done) begin
                    if (!enable) abort = 1'b1;
                    else         advance = 1'b1;
                end
            end
            StMute: begin
                wr_start = wr_idle;
                if (wr_done) begin
                    if (wr_idx == PSG_REG_VOL_C) begin
                        state_d = StIdle;
                        muted_d = 1'b1;
                    end else begin
                        mute_cnt_d = mute_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d    = StMute;
            mute_cnt_d = 2'd0;
        end else if (advance) begin
            if (reg_idx_q == LastIdx) begin
                frame_done_d = 1'b1;
                state_d      = StIdle;
            end else begin
                reg_idx_d = reg_idx_q + 4'd1;
                state_d   = StFetch;
            end
        end

        // Re-arm the one-shot idle mute whenever playback is enabled again.
        if (enable) muted_d = 1'b0;

        overrun_d = overrun;
        if (clr_err) overrun_d = 1'b0;
        if (frame_tick && (state_q != StIdle)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            reg_idx_q  <= 4'd0;
            mute_cnt_q <= 2'd0;
            muted_q    <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            mute_cnt_q <= mute_cnt_d;
            muted_q    <= muted_d;
            in_ready   <= (state_d == StFetch);
            busy       <= (state_d != StIdle);
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

    psg_bus_writer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .start     (wr_start),
        .reg_idx   (wr_idx),
        .data      (wr_data),
        .idle      (wr_idle),
        .done      (wr_done),
        .psg_a0    (psg_a0),
        .psg_wren  (psg_wren),
        .psg_wrdata(psg_wrdata)
    );

endmodule
